// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue stimulus generator.
package pq_pkg;

  localparam int unsigned KW_DEF = 8;
  localparam int unsigned VW_DEF = 8;
  localparam int unsigned LFSR_W = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1, i.e. bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stim_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shift-left, advancing only when enabled.
module lfsr8
  import pq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (enable) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/pq_stim_gen.sv
// Self-running stimulus source: fills the priority queue with LFSR keys, then drains it.
module pq_stim_gen
  import pq_pkg::*;
#(
  parameter int unsigned       KW          = KW_DEF,
  parameter int unsigned       VW          = VW_DEF,
  parameter int unsigned       NUM_ENTRIES = 16,
  parameter logic [LFSR_W-1:0] SEED        = 8'h01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pq_ready,
  input  logic          pq_full,
  input  logic          pq_empty,
  output logic          add_valid,
  output logic [KW-1:0] data1,
  output logic [VW-1:0] data2,
  output logic          remove_req,
  output logic          busy,
  output logic          done
);

  localparam int unsigned IW       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  stim_state_t       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     idx_inc;
  logic              start_q;
  logic              add_valid_q, add_valid_d;
  logic [KW-1:0]     data1_q, data1_d;
  logic [VW-1:0]     data2_q, data2_d;
  logic              remove_req_q, remove_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wait_q, wait_d;
  logic              lfsr_en;
  logic [LFSR_W-1:0] lfsr_q;
  logic              start_rise;
  logic              xfer;

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (lfsr_en),
    .load   (1'b0),
    .seed   (SEED),
    .q      (lfsr_q)
  );

  assign start_rise = start & ~start_q;
  // Full wins over ready: no transfer while the queue reports full
  assign xfer       = add_valid_q & pq_ready & ~pq_full;
  assign idx_inc    = IW'(idx_q + 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      start_q      <= 1'b0;
      add_valid_q  <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      remove_req_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wait_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      start_q      <= start;
      add_valid_q  <= add_valid_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      remove_req_q <= remove_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wait_q       <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    add_valid_d  = add_valid_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    remove_req_d = 1'b0;
    wait_d       = wait_q;
    lfsr_en      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d     = FILL;
          idx_d       = '0;
          add_valid_d = 1'b1;
          data1_d     = KW'(lfsr_q);
          data2_d     = '0;
        end
      end
      FILL: begin
        // The LFSR always holds the key on offer, so it steps on every accepted pair
        if (xfer) begin
          lfsr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            add_valid_d = 1'b0;
            wait_d      = 1'b0;
            state_d     = DRAIN;
          end else begin
            idx_d   = idx_inc;
            data1_d = KW'(lfsr_next(lfsr_q));
            data2_d = VW'(idx_inc);
          end
        end
      end
      DRAIN: begin
        // Alternate remove and settle cycles so pq_empty is fresh when sampled
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (pq_empty) begin
          state_d = DONE;
        end else begin
          remove_req_d = 1'b1;
          wait_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FILL) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  assign add_valid  = add_valid_q;
  assign data1      = data1_q;
  assign data2      = data2_q;
  assign remove_req = remove_req_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pq_stim_gen.sv
// Randomized bench for pq_stim_gen against a transaction-level queue/LFSR model.
module tb_pq_stim_gen;

  localparam int unsigned KW = 8;
  localparam int unsigned VW = 8;
  localparam int unsigned N  = 16;
  localparam logic [7:0]  SEED = 8'h01;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pq_ready;
  logic          pq_full;
  logic          pq_empty;
  logic          add_valid;
  logic [KW-1:0] data1;
  logic [VW-1:0] data2;
  logic          remove_req;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pq_stim_gen #(
    .KW(KW), .VW(VW), .NUM_ENTRIES(N), .SEED(SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pq_ready   (pq_ready),
    .pq_full    (pq_full),
    .pq_empty   (pq_empty),
    .add_valid  (add_valid),
    .data1      (data1),
    .data2      (data2),
    .remove_req (remove_req),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         m_phase;
  logic [7:0] m_key;
  int         m_xfer;
  int         m_rem;
  int         q_cnt;
  bit         prev_start;
  bit         prev_rem;
  bit         tbl_on;
  logic [7:0] key_tbl [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] k);
    logic fb;
    fb = k[7] ^ k[5] ^ k[4] ^ k[3];
    return {k[6:0], fb};
  endfunction

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_add_valid"}, add_valid, 0);
    check_eq({pfx, "_data1"}, data1, 0);
    check_eq({pfx, "_data2"}, data2, 0);
    check_eq({pfx, "_remove_req"}, remove_req, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
  endtask

  // Entered and left at a negedge
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    start = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    m_phase = M_IDLE;
    m_key = SEED;
    m_xfer = 0;
    m_rem = 0;
    q_cnt = 0;
    prev_start = 1'b0;
    prev_rem = 1'b0;
  endtask

  // Observe outputs, drive inputs, advance one clock, update the model
  task automatic step(input bit rdy, input bit full, input bit st);
    bit xfer;
    bit rem;
    bit rise;
    check_eq("add_valid", add_valid, m_phase == M_FILL);
    if (add_valid) begin
      check_eq("key", data1, m_key);
      check_eq("idx", data2, m_xfer);
      if (tbl_on && m_xfer < 6) check_eq("key_tbl", data1, key_tbl[m_xfer]);
    end
    if (m_phase == M_DRAIN && done) begin
      check_eq("drain_removes", m_rem, N);
      check_eq("drain_qcnt", q_cnt, 0);
      m_phase = M_DONE;
    end
    check_eq("busy", busy, (m_phase == M_FILL) || (m_phase == M_DRAIN));
    check_eq("done", done, m_phase == M_DONE);
    if (remove_req) begin
      check_eq("rem_in_drain", m_phase == M_DRAIN, 1);
      check_eq("rem_spacing", prev_rem, 0);
      check_eq("rem_nonempty", q_cnt != 0, 1);
    end

    pq_ready = rdy;
    pq_full  = full;
    start    = st;
    pq_empty = (q_cnt == 0);
    xfer = add_valid & rdy & ~full;
    rem  = remove_req;
    rise = st & ~prev_start;
    prev_rem = rem;
    @(posedge clk);
    prev_start = st;
    if ((m_phase == M_IDLE || m_phase == M_DONE) && rise) begin
      m_phase = M_FILL;
      m_xfer = 0;
      m_rem = 0;
    end else if (xfer) begin
      q_cnt++;
      m_xfer++;
      m_key = ref_step(m_key);
      if (m_xfer == N) m_phase = M_DRAIN;
    end
    if (rem) begin
      m_rem++;
      if (q_cnt > 0) q_cnt--;
    end
    @(negedge clk);
  endtask

  task automatic run_pass(input bit directed, input int rst_at, input bit tbl);
    int guard;
    int stall4;
    int full7;
    bit r;
    bit f;
    bit s;
    stall4 = 0;
    full7 = 0;
    tbl_on = tbl;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (m_phase != M_DONE && guard < 400) begin
      if (rst_at >= 0 && m_phase == M_DRAIN && m_rem == rst_at) begin
        do_reset(1);
        check_zero_outputs("drain_rst");
        return;
      end
      if (directed) begin
        r = 1'b1;
        f = 1'b0;
        s = 1'b1;
        if (m_phase == M_FILL && m_xfer == 4 && stall4 < 3) begin
          r = 1'b0;
          stall4++;
        end else if (m_phase == M_FILL && m_xfer == 7 && full7 < 3) begin
          f = 1'b1;
          full7++;
        end
      end else begin
        r = ($urandom_range(0, 3) != 0);
        f = ($urandom_range(0, 7) == 0);
        s = 1'($urandom_range(0, 1));
      end
      step(r, f, s);
      guard++;
    end
    check_eq("pass_reached_done", m_phase == M_DONE, 1);
  endtask

  initial begin
    pq_ready = 1'b0;
    pq_full  = 1'b0;
    pq_empty = 1'b1;
    start    = 1'b0;
    rst      = 1'b0;
    tbl_on   = 1'b0;
    @(negedge clk);
    do_reset(2);
    check_zero_outputs("reset");
    repeat (10) step(1'b1, 1'b0, 1'b0);

    run_pass(1'b1, -1, 1'b1);
    // start held high in DONE must not retrigger
    repeat (3) step(1'b1, 1'b0, 1'b1);
    run_pass(1'b0, -1, 1'b0);
    run_pass(1'b0, 5, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    run_pass(1'b1, -1, 1'b1);
    for (int p = 0; p < 4; p++) run_pass(1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
